fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Front-end stage directly upstream of the execute/memory backend.
- Owns the program counter and fetches one instruction at a time from instruction memory over a req/ack handshake.
- Presents each instruction to decode with a valid/ready handshake.
- Resolves the next PC from decode's active-low branch/jump controls and the backend's active-low compare flags (is_lt, is_ltu, is_zero).
- Non-speculative, single outstanding fetch. Also maintains a retired-instruction counter and a fault/halt state.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (must be 4-byte aligned)
ACK_TIMEOUT, 16, max cycles imem_req may wait for imem_ack before fault; 0 disables the timeout

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active high
imem_req  output  1  fetch request, held until ack
imem_addr  output  32  fetch address, stable while imem_req=1
imem_ack  input  1  memory returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
inst  output  32  instruction presented to decode
inst_pc  output  32  address of inst
link_addr  output  32  inst_pc+4, used for JAL/JALR rd writeback
inst_valid  output  1  inst/inst_pc valid
inst_ready  input  1  decode/backend accepts inst this cycle
br_op  input  6  branch one-hot, ACTIVE LOW: [5]beq [4]bne [3]blt [2]bge [1]bltu [0]bgeu
jal  input  1  JAL, ACTIVE LOW
jalr  input  1  JALR, ACTIVE LOW
imm  input  32  sign-extended B/J immediate
jalr_target  input  32  rs1+imm from backend ALU
is_lt  input  1  backend flag, ACTIVE LOW (0 = signed less-than)
is_ltu  input  1  backend flag, ACTIVE LOW (0 = unsigned less-than)
is_zero  input  1  backend flag, ACTIVE LOW (0 = operands equal)
fault  output  1  sticky: misaligned target or fetch timeout
fault_addr  output  32  offending target or timed-out fetch address
retired_count  output  32  count of accepted instructions, wraps at 2^32

Behaviour:
- **Reset values** (rst=1 at an edge, regardless of state):
  - state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, link_addr=RESET_PC+4, inst_valid=0.
  - fault=0, fault_addr=0, retired_count=0, timeout counter=0.
  - Any in-flight request is abandoned.
- **BOOT:** one cycle, imem_req=0 → FETCH.
- **FETCH:** imem_req=1, imem_addr=pc.
  - On imem_ack=1: register inst=imem_rdata, inst_pc=pc, link_addr=pc+4 → ISSUE.
  - Timeout counter increments each cycle without ack. When it reaches ACK_TIMEOUT (and ACK_TIMEOUT≠0): fault_addr=pc, → HALT.
- **ISSUE:** inst_valid=1, imem_req=0. inst/inst_pc are held stable until accept.
  - Accept = inst_valid & inst_ready. On accept: retired_count+=1, next pc computed (below) → FETCH, and the timeout counter is cleared.
- **HALT:** fault=1, imem_req=0, inst_valid=0. Only rst exits.
- **imem_ack handling:** ack outside FETCH is ignored. This includes a late ack arriving the cycle after reset or after HALT entry.
- **Latency:** ack in the first FETCH cycle → inst_valid the next cycle. Best throughput is 1 instruction per 2 cycles.
- **Next-PC selection** (sampled in the accept cycle; controls and flags are combinational from decode/backend). Priority: jalr > jal > branch > sequential.
  - jalr=0: target = jalr_target & ~32'h1.
  - jal=0: target = inst_pc + imm.
  - Branch taken: target = inst_pc + imm. Taken conditions:
    - beq: is_zero=0. bne: is_zero=1.
    - blt: is_lt=0. bge: is_lt=1.
    - bltu: is_ltu=0. bgeu: is_ltu=1.
  - Otherwise (including a not-taken branch): target = inst_pc + 4.
  - More than one br_op bit low: the highest index wins.
- **Arithmetic:** all address arithmetic is modulo 2^32. PC 32'hFFFF_FFFC + 4 → 32'h0000_0000 with no fault.
- **Misaligned target:** target[1:0]≠0 after JALR bit-0 clear means only target[1]=1 can occur. Then: no fetch, fault_addr=target, → HALT. The faulting instruction still counts as retired.
- **inst_ready outside ISSUE:** ignored, no count.
- **rst with inst_valid=1:** the instruction is dropped and not counted.

Test Plan:
1. Reset then sequential fetch:
   - Stimulus: rst 2 cycles; mem acks in 1 cycle with rdata=0x00000013; inst_ready=1; RESET_PC=0x100.
   - Required: imem_addr 0x100, 0x104, 0x108; inst_valid every 2nd cycle; retired_count=3 after 3 accepts.
2. Branches at inst_pc=0x200, imm=0xFFFFFFF0:
   - beq with is_zero=0 → next fetch 0x1F0.
   - bne with is_zero=0 → 0x204.
   - bltu with is_ltu=0 → 0x1F0.
   - bge with is_lt=0 → 0x204.
3. JALR:
   - jalr=0, jalr_target=0x0000_1003, jal=0 simultaneously → next fetch 0x1002 misaligned → fault=1, fault_addr=0x1002, imem_req=0 thereafter.
   - jalr_target=0x1001 → fetch 0x1000, link_addr=inst_pc+4.
4. Handshake stress:
   - Ack delayed 5 cycles → imem_addr stable; inst_valid stays 0 until ack.
   - inst_ready low 3 cycles in ISSUE → inst/inst_pc constant; retired_count unchanged.
   - Spurious ack in ISSUE ignored.
5. Timeout and reset mid-operation:
   - No ack with ACK_TIMEOUT=16 → fault at 16th waiting cycle, fault_addr=pc.
   - rst asserted in FETCH with ack the next cycle → ack ignored, fetch restarts at RESET_PC after BOOT.
6. Wrap-around: RESET_PC=0xFFFF_FFFC, sequential instruction → next imem_addr=0x0000_0000, fault=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Front-end stage: owns the program counter, fetches one instruction at a
//   time from instruction memory (req/ack), presents it to decode
//   (valid/ready) and resolves the next PC from decode's active-low
//   branch/jump controls and the backend's active-low compare flags.
//   Non-speculative with a single outstanding fetch. Also keeps a
//   retired-instruction counter and a sticky fault/halt state.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/imem_addr        fetch request and address (registered)
//   imem_ack/imem_rdata       memory response
//   inst/inst_pc/link_addr    instruction, its address, address + 4
//   inst_valid/inst_ready     decode handshake
//   br_op/jal/jalr            active-low control from decode
//   imm/jalr_target           branch/JAL offset and JALR target
//   is_lt/is_ltu/is_zero      active-low compare flags from backend
//   fault/fault_addr          sticky halt indication and offending address
//   retired_count             accepted instruction count (wraps)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] link_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [5:0]  br_op,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] jalr_target,
    input  logic        is_lt,
    input  logic        is_ltu,
    input  logic        is_zero,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] link_addr_q, link_addr_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] tmo_q, tmo_d;
    logic        imem_req_q, imem_req_d;
    logic        inst_valid_q, inst_valid_d;
    logic        fault_q, fault_d;

    logic [31:0] target_s;
    logic [31:0] tmo_inc_s;
    logic        timeout_s;

    // Branch decision: the highest-index asserted (low) br_op bit selects the condition.
    function automatic logic branch_taken(input logic [5:0] br_n,
                                          input logic lt_n,
                                          input logic ltu_n,
                                          input logic zero_n);
        logic taken;
        if (!br_n[5]) begin
            taken = !zero_n;
        end else if (!br_n[4]) begin
            taken = zero_n;
        end else if (!br_n[3]) begin
            taken = !lt_n;
        end else if (!br_n[2]) begin
            taken = lt_n;
        end else if (!br_n[1]) begin
            taken = !ltu_n;
        end else if (!br_n[0]) begin
            taken = ltu_n;
        end else begin
            taken = 1'b0;
        end
        return taken;
    endfunction

    // Next-PC selection, priority jalr > jal > taken branch > sequential.
    always_comb begin
        target_s = inst_pc_q + 32'd4;
        if (!jalr) begin
            target_s = jalr_target & 32'hFFFF_FFFE;
        end else if (!jal) begin
            target_s = inst_pc_q + imm;
        end else if (branch_taken(br_op, is_lt, is_ltu, is_zero)) begin
            target_s = inst_pc_q + imm;
        end else begin
            target_s = inst_pc_q + 32'd4;
        end
    end

    // Fetch wait timer; a zero ACK_TIMEOUT never expires.
    always_comb begin
        tmo_inc_s = tmo_q + 32'd1;
        if (ACK_TIMEOUT != 32'd0) begin
            timeout_s = (tmo_inc_s == ACK_TIMEOUT);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Sequencer next-state and datapath next values; outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        link_addr_d  = link_addr_q;
        fault_addr_d = fault_addr_q;
        retired_d    = retired_q;
        tmo_d        = tmo_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d      = imem_rdata;
                    inst_pc_d   = pc_q;
                    link_addr_d = pc_q + 32'd4;
                    state_d     = ST_ISSUE;
                end else if (timeout_s) begin
                    tmo_d        = tmo_inc_s;
                    fault_addr_d = pc_q;
                    state_d      = ST_HALT;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            ST_ISSUE: begin
                // Acks arriving here are spurious and ignored.
                if (inst_ready) begin
                    retired_d = retired_q + 32'd1;
                    tmo_d     = 32'd0;
                    if (target_s[1:0] != 2'b00) begin
                        fault_addr_d = target_s;
                        state_d      = ST_HALT;
                    end else begin
                        pc_d    = target_s;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        imem_req_d   = (state_d == ST_FETCH);
        inst_valid_d = (state_d == ST_ISSUE);
        fault_d      = (state_d == ST_HALT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_pc_q    <= RESET_PC;
            link_addr_q  <= RESET_PC + 32'd4;
            fault_addr_q <= 32'd0;
            retired_q    <= 32'd0;
            tmo_q        <= 32'd0;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            link_addr_q  <= link_addr_d;
            fault_addr_q <= fault_addr_d;
            retired_q    <= retired_d;
            tmo_q        <= tmo_d;
            imem_req_q   <= imem_req_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign imem_req      = imem_req_q;
    assign imem_addr     = pc_q;
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign link_addr     = link_addr_q;
    assign inst_valid    = inst_valid_q;
    assign fault         = fault_q;
    assign fault_addr    = fault_addr_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer with a transaction-level reference
//   model (handshake obligations, fetch address, retired count, fault) that is
//   compared against the DUT on every falling edge, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic [31:0] inst, inst_pc, link_addr;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [5:0]  br_op = 6'h3F;
    logic        jal = 1'b1, jalr = 1'b1;
    logic [31:0] imm = 32'd0, jalr_target = 32'd0;
    logic        is_lt = 1'b1, is_ltu = 1'b1, is_zero = 1'b1;
    logic        fault;
    logic [31:0] fault_addr, retired_count;

    // memory responder controls
    int mem_delay = 0;
    int mem_wait = 0;
    bit mem_mute = 1'b0;
    bit force_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(RPC), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .inst_pc(inst_pc), .link_addr(link_addr),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .br_op(br_op), .jal(jal), .jalr(jalr),
        .imm(imm), .jalr_target(jalr_target),
        .is_lt(is_lt), .is_ltu(is_ltu), .is_zero(is_zero),
        .fault(fault), .fault_addr(fault_addr), .retired_count(retired_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_for(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    // Architectural next-PC rule.
    function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [5:0] br,
                                                 input logic jal_n, input logic jalr_n,
                                                 input logic [31:0] im, input logic [31:0] jt,
                                                 input logic lt_n, input logic ltu_n, input logic z_n);
        logic [5:0]  cond;
        logic [31:0] t;
        bit          found;
        cond  = {~z_n, z_n, ~lt_n, lt_n, ~ltu_n, ltu_n};
        t     = pc + 32'd4;
        found = 1'b0;
        if (!jalr_n) begin
            t = {jt[31:1], 1'b0};
        end else if (!jal_n) begin
            t = pc + im;
        end else begin
            for (int i = 5; i >= 0; i--) begin
                if (!found && !br[i]) begin
                    found = 1'b1;
                    if (cond[i]) t = pc + im;
                end
            end
        end
        return t;
    endfunction

    // Instruction memory: acks after mem_delay waiting cycles; force_ack drives
    // an ack while no request is pending.
    always @(posedge clk) begin
        #2;
        if (imem_req && !mem_mute) begin
            if (mem_wait >= mem_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = word_for(imem_addr);
                mem_wait   = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                mem_wait++;
            end
        end else begin
            imem_ack   = force_ack;
            imem_rdata = 32'hDEAD_BEEF;
            mem_wait   = 0;
        end
    end

    // Reference model state
    bit          m_live = 1'b0, m_boot = 1'b0, m_req_due = 1'b0, m_valid_due = 1'b0, m_fault = 1'b0;
    logic [31:0] m_fetch_addr = RPC, m_inst = 32'd0, m_inst_pc = 32'd0;
    logic [31:0] m_fault_addr = 32'd0, m_count = 32'd0;
    int          m_wait = 0;

    // Compare DUT against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        bit          req_now, valid_now;
        logic [31:0] t;
        if (m_live) begin
            check("m_req", 32'(imem_req), 32'(m_req_due));
            check("m_valid", 32'(inst_valid), 32'(m_valid_due));
            check("m_fault", 32'(fault), 32'(m_fault));
            check("m_fault_addr", fault_addr, m_fault ? m_fault_addr : 32'd0);
            check("m_retired", retired_count, m_count);
            if (m_req_due) check("m_imem_addr", imem_addr, m_fetch_addr);
            if (m_valid_due) begin
                check("m_inst", inst, m_inst);
                check("m_inst_pc", inst_pc, m_inst_pc);
                check("m_link", link_addr, m_inst_pc + 32'd4);
            end
        end
        req_now     = m_req_due;
        valid_now   = m_valid_due;
        m_req_due   = 1'b0;
        m_valid_due = 1'b0;
        if (rst) begin
            m_live = 1'b1; m_boot = 1'b1; m_fault = 1'b0; m_fault_addr = 32'd0;
            m_count = 32'd0; m_wait = 0; m_fetch_addr = RPC;
        end else if (!m_live || m_fault) begin
            m_req_due = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_req_due = 1'b1;
        end else if (req_now) begin
            if (imem_ack) begin
                m_inst = word_for(m_fetch_addr); m_inst_pc = m_fetch_addr; m_valid_due = 1'b1;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_fault = 1'b1; m_fault_addr = m_fetch_addr;
                end else begin
                    m_req_due = 1'b1;
                end
            end
        end else if (valid_now) begin
            if (inst_ready) begin
                m_count++;
                m_wait = 0;
                t = model_target(m_inst_pc, br_op, jal, jalr, imm, jalr_target, is_lt, is_ltu, is_zero);
                if (t[1:0] != 2'b00) begin
                    m_fault = 1'b1; m_fault_addr = t;
                end else begin
                    m_fetch_addr = t; m_req_due = 1'b1;
                end
            end else begin
                m_valid_due = 1'b1;
            end
        end else begin
            m_req_due = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_rise();
        bit prev;
        int n = 0;
        prev = imem_req;
        step();
        while (!(imem_req && !prev) && n < 50) begin
            prev = imem_req;
            step();
            n++;
        end
        check("req_rise_seen", 32'(imem_req), 32'd1);
    endtask

    task automatic expect_fetch(input logic [31:0] exp);
        int n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        check("fetch_seen", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, exp);
    endtask

    // Wait for an issued instruction, accept it for one cycle with the given controls.
    task automatic accept_with(input logic [5:0] b, input logic j_n, input logic jr_n,
                               input logic [31:0] im, input logic [31:0] jt,
                               input logic lt_n, input logic ltu_n, input logic z_n);
        int n = 0;
        while (!inst_valid && n < 50) begin
            step();
            n++;
        end
        check("issue_seen", 32'(inst_valid), 32'd1);
        br_op = b; jal = j_n; jalr = jr_n; imm = im; jalr_target = jt;
        is_lt = lt_n; is_ltu = ltu_n; is_zero = z_n; inst_ready = 1'b1;
        step();
        inst_ready = 1'b0; br_op = 6'h3F; jal = 1'b1; jalr = 1'b1; imm = 32'd0;
        jalr_target = 32'd0; is_lt = 1'b1; is_ltu = 1'b1; is_zero = 1'b1;
    endtask

    localparam logic [31:0] NEG16 = 32'hFFFF_FFF0;

    initial begin
        logic [31:0] seq_addr [3];
        int cyc;
        seq_addr = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};

        // reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0100);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'h0000_0100);
        check("rst_link", link_addr, 32'h0000_0104);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_addr", fault_addr, 32'd0);
        check("rst_retired", retired_count, 32'd0);
        rst = 1'b0;

        // sequential fetch with decode always ready
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_req_rise();
            check("seq_addr", imem_addr, seq_addr[k]);
        end
        step();
        step();
        inst_ready = 1'b0;
        check("seq_retired", retired_count, 32'd3);

        // branches around 0x200
        accept_with(6'h3F, 1'b0, 1'b1, 32'h0000_00F4, 32'd0, 1'b1, 1'b1, 1'b1);
        expect_fetch(32'h0000_0200);
        accept_with(6'b01_1111, 1'b1, 1'b1, NEG16, 32'd0, 1'b1, 1'b1, 1'b0);
        expect_fetch(32'h0000_01F0);
        accept_with(6'h3F, 1'b0, 1'b1, 32'h0000_0010, 32'd0, 1'b1, 1'b1, 1'b1);
        expect_fetch(32'h0000_0200);
        accept_with(6'b10_1111, 1'b1, 1'b1, NEG16, 32'd0, 1'b1, 1'b1, 1'b0);
        expect_fetch(32'h0000_0204);
        accept_with(6'h3F, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'd0, 1'b1, 1'b1, 1'b1);
        expect_fetch(32'h0000_0200);
        accept_with(6'b11_1101, 1'b1, 1'b1, NEG16, 32'd0, 1'b1, 1'b0, 1'b1);
        expect_fetch(32'h0000_01F0);
        accept_with(6'h3F, 1'b0, 1'b1, 32'h0000_0010, 32'd0, 1'b1, 1'b1, 1'b1);
        expect_fetch(32'h0000_0200);
        accept_with(6'b11_1011, 1'b1, 1'b1, NEG16, 32'd0, 1'b0, 1'b1, 1'b1);
        expect_fetch(32'h0000_0204);
        // beq and bne both low: beq decides (not equal -> not taken)
        accept_with(6'b00_1111, 1'b1, 1'b1, NEG16, 32'd0, 1'b1, 1'b1, 1'b1);
        expect_fetch(32'h0000_0208);

        // wrap-around via JALR to the top word
        accept_with(6'h3F, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b1);
        expect_fetch(32'hFFFF_FFFC);
        step();
        check("wrap_valid", 32'(inst_valid), 32'd1);
        check("wrap_link", link_addr, 32'h0000_0000);
        accept_with(6'h3F, 1'b1, 1'b1, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
        expect_fetch(32'h0000_0000);
        check("wrap_fault", 32'(fault), 32'd0);

        // JALR with odd target
        accept_with(6'h3F, 1'b1, 1'b0, 32'd0, 32'h0000_1001, 1'b1, 1'b1, 1'b1);
        expect_fetch(32'h0000_1000);
        step();
        check("jalr_valid", 32'(inst_valid), 32'd1);
        check("jalr_link", link_addr, 32'h0000_1004);
        check("jalr_inst", inst, 32'h5A00_1013);

        // decode stall with spurious acks
        force_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_inst_pc", inst_pc, 32'h0000_1000);
            check("stall_retired", retired_count, 32'd15);
        end
        force_ack = 1'b0;

        // delayed memory ack
        mem_delay = 5;
        accept_with(6'h3F, 1'b1, 1'b1, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
        expect_fetch(32'h0000_1004);
        cyc = 0;
        while (imem_req && cyc < 20) begin
            cyc++;
            step();
        end
        check("delay_req_cycles", 32'(cyc), 32'd6);
        check("delay_valid", 32'(inst_valid), 32'd1);
        mem_delay = 0;

        // JALR has priority over JAL; misaligned target halts
        accept_with(6'h3F, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_1003, 1'b1, 1'b1, 1'b1);
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_fault_addr", fault_addr, 32'h0000_1002);
        check("mis_req", 32'(imem_req), 32'd0);
        check("mis_retired", retired_count, 32'd17);
        force_ack = 1'b1;
        repeat (3) step();
        force_ack = 1'b0;
        check("halt_req", 32'(imem_req), 32'd0);
        check("halt_fault", 32'(fault), 32'd1);

        // fetch timeout
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        mem_mute = 1'b1;
        cyc = 0;
        while (!imem_req && cyc < 10) begin
            cyc++;
            step();
        end
        cyc = 0;
        while (imem_req && cyc < 40) begin
            cyc++;
            step();
        end
        check("tmo_cycles", 32'(cyc), 32'd16);
        check("tmo_fault", 32'(fault), 32'd1);
        check("tmo_fault_addr", fault_addr, 32'h0000_0100);
        check("tmo_retired", retired_count, 32'd0);

        // reset during fetch followed by a late ack
        mem_mute  = 1'b0;
        mem_delay = 10;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rr_req1", 32'(imem_req), 32'd1);
        check("rr_addr1", imem_addr, 32'h0000_0100);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        force_ack = 1'b1;
        check("rr_boot_req", 32'(imem_req), 32'd0);
        step();
        force_ack = 1'b0;
        mem_delay = 0;
        check("rr_req2", 32'(imem_req), 32'd1);
        check("rr_addr2", imem_addr, 32'h0000_0100);
        step();
        check("rr_valid", 32'(inst_valid), 32'd1);
        check("rr_inst", inst, 32'h5A00_0113);
        check("rr_inst_pc", inst_pc, 32'h0000_0100);
        check("rr_link", link_addr, 32'h0000_0104);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
